// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: shared types and constants for the end-of-test monitor.
//   tm_state_t          - monitor FSM state encoding
//   TM_GP_PASS          - gp / tohost value that signals a passing test
//   TM_TOHOST_DONE_BIT  - tohost data bit that marks the store as an end-of-test report
package test_monitor_pkg;

    typedef enum logic [2:0] {
        StRun,
        StSettle,
        StPass,
        StFail,
        StTimeout
    } tm_state_t;

    localparam int unsigned TM_GP_PASS         = 1;
    localparam int unsigned TM_TOHOST_DONE_BIT = 0;

endpackage

// File: rtl/test_monitor_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset, clears the count
//   en   - increment this cycle (ignored once saturated)
//   clr  - synchronous clear, has priority over en
//   cnt  - current count (registered)
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/test_monitor.sv
// test_monitor: end-of-test monitor for riscv-tests programs on the pipelined RV32 core.
// Watches the fetch PC for the completion address, waits for the pipeline to drain,
// then samples gp (x3) to decide pass/fail. A cycle limit yields a timeout verdict.
// All verdicts are sticky until reset; all outputs are registered.
//
// Optional feature: define TEST_MONITOR_TOHOST_EN to add the st_* ports and end the test
// immediately on a store to TOHOST_ADDR with data bit 0 set.
//
// Ports:
//   clk       - core clock, rising edge
//   rst       - asynchronous active-low reset
//   pc_valid  - pc holds a valid fetch PC this cycle
//   pc        - core fetch PC
//   gp        - current register-file value of x3
//   st_valid  - data store issued this cycle        (TEST_MONITOR_TOHOST_EN only)
//   st_addr   - store address                       (TEST_MONITOR_TOHOST_EN only)
//   st_data   - store data                          (TEST_MONITOR_TOHOST_EN only)
//   done      - a verdict is available
//   pass      - test passed (meaningful while done)
//   timed_out - test ended by timeout
//   fail_test - failing test number (reported value >> 1)
//   cycles    - cycles spent in RUN and SETTLE
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int unsigned    XLEN          = 32,
    parameter int unsigned    PC_W          = 32,
    parameter logic [PC_W-1:0] DONE_PC      = 'h44,
    parameter int unsigned    SETTLE_CYCLES = 2,
    parameter int unsigned    TIMEOUT       = 6000,
    parameter int unsigned    CNT_W         = 32,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = 'h1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_valid,
    input  logic [PC_W-1:0]   pc,
    input  logic [XLEN-1:0]   gp,
`ifdef TEST_MONITOR_TOHOST_EN
    input  logic              st_valid,
    input  logic [XLEN-1:0]   st_addr,
    input  logic [XLEN-1:0]   st_data,
`endif
    output logic              done,
    output logic              pass,
    output logic              timed_out,
    output logic [XLEN-2:0]   fail_test,
    output logic [CNT_W-1:0]  cycles
);

    // The settle counter runs 0..SETTLE_CYCLES-1; the verdict is taken on the edge that
    // follows the last value, i.e. SETTLE_CYCLES edges after the match edge.
    localparam int unsigned SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

    tm_state_t             state_d, state_q;
    logic                  done_d, done_q;
    logic                  pass_d, pass_q;
    logic                  timed_out_d, timed_out_q;
    logic [XLEN-2:0]       fail_test_d, fail_test_q;

    logic [SETTLE_W-1:0]   settle_cnt;
    logic [CNT_W-1:0]      cycle_cnt;
    logic                  cycle_en;

    logic                  pc_match;
    logic                  settle_done;
    logic                  timeout_hit;
    logic                  tohost_hit;
    // Value the verdict is decided on: the tohost data when a tohost store ends the
    // test, gp otherwise.
    logic [XLEN-1:0]       verdict_val;

    assign pc_match    = pc_valid && (pc == DONE_PC);
    assign settle_done = (settle_cnt == SETTLE_W'(SETTLE_LAST));
    assign timeout_hit = (cycle_cnt == CNT_W'(TIMEOUT - 1));

`ifdef TEST_MONITOR_TOHOST_EN
    assign tohost_hit  = st_valid && (st_addr == TOHOST_ADDR) && st_data[TM_TOHOST_DONE_BIT];
    assign verdict_val = tohost_hit ? st_data : gp;
`else
    assign tohost_hit  = 1'b0;
    assign verdict_val = gp;
    localparam logic [XLEN-1:0] unused_tohost_addr = TOHOST_ADDR;
`endif

    always_comb begin
        state_d     = state_q;
        done_d      = done_q;
        pass_d      = pass_q;
        timed_out_d = timed_out_q;
        fail_test_d = fail_test_q;

        unique case (state_q)
            StRun: begin
                // Priority: tohost store, then PC match, then timeout.
                if (tohost_hit || (pc_match && (SETTLE_CYCLES == 0))) begin
                    done_d = 1'b1;
                    if (verdict_val == XLEN'(TM_GP_PASS)) begin
                        state_d = StPass;
                        pass_d  = 1'b1;
                    end else begin
                        state_d     = StFail;
                        fail_test_d = verdict_val[XLEN-1:1];
                    end
                end else if (pc_match) begin
                    state_d = StSettle;
                end else if (timeout_hit) begin
                    state_d     = StTimeout;
                    done_d      = 1'b1;
                    timed_out_d = 1'b1;
                end
            end
            StSettle: begin
                if (settle_done) begin
                    done_d = 1'b1;
                    if (gp == XLEN'(TM_GP_PASS)) begin
                        state_d = StPass;
                        pass_d  = 1'b1;
                    end else begin
                        state_d     = StFail;
                        fail_test_d = gp[XLEN-1:1];
                    end
                end
            end
            default: begin
                // Terminal states hold until reset.
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            fail_test_q <= '0;
        end else begin
            state_q     <= state_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            timed_out_q <= timed_out_d;
            fail_test_q <= fail_test_d;
        end
    end

    // The timeout edge itself does not count, so cycles reads TIMEOUT-1 afterwards.
    assign cycle_en = ((state_q == StRun) && (state_d != StTimeout)) || (state_q == StSettle);

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cycle_en),
        .clr (1'b0),
        .cnt (cycle_cnt)
    );

    sat_counter #(
        .W (SETTLE_W)
    ) u_settle_cnt (
        .clk (clk),
        .rst (rst),
        .en  (state_q == StSettle),
        .clr (state_q != StSettle),
        .cnt (settle_cnt)
    );

    assign done      = done_q;
    assign pass      = pass_q;
    assign timed_out = timed_out_q;
    assign fail_test = fail_test_q;
    assign cycles    = cycle_cnt;

endmodule

// File: doc/test_monitor.md
# test_monitor

Synthesizable end-of-test monitor for the pipelined RV32 core running riscv-tests programs. It observes the fetch PC and the test-status register (x3/gp) and decides pass, fail or timeout. It reports a registered verdict, the failing test number and the elapsed cycle count, replacing per-test hard-coded bench checks. Instantiated beside `Core` in every test bench and usable on FPGA builds, where it drives status LEDs.

## Interface
- `XLEN`, 32, data width of the gp sample and the store data.
- `PC_W`, 32, width of the PC.
- `DONE_PC`, 32'h44, PC value that marks test completion.
- `SETTLE_CYCLES`, 2, cycles waited after the PC match before gp is sampled, so that earlier writes drain from the pipeline.
- `TIMEOUT`, 6000, cycle limit (≥1) for reaching completion.
- `CNT_W`, 32, cycle counter width.
- `TOHOST_ADDR`, 32'h1000, tohost store address. Used only with `TEST_MONITOR_TOHOST_EN`.
- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  reset. Asynchronous, active-low.
- `pc_valid`  in  1  `pc` holds a valid fetch PC this cycle.
- `pc`  in  PC_W  core fetch PC (`if_pc`).
- `gp`  in  XLEN  current register-file value of x3.
- `st_valid`  in  1  data store issued this cycle. Port exists only with the macro.
- `st_addr`  in  XLEN  store address. Port exists only with the macro.
- `st_data`  in  XLEN  store data. Port exists only with the macro.
- `done`  out  1  a verdict is available.
- `pass`  out  1  the test passed. Meaningful only while `done` is high.
- `timed_out`  out  1  the test ended by timeout.
- `fail_test`  out  XLEN-1  failing test number (gp >> 1).
- `cycles`  out  CNT_W  cycles spent in RUN and SETTLE.

## Operation
- States and transitions:
  - RUN → SETTLE on `pc_valid && pc == DONE_PC`.
  - RUN → TIMEOUT when `cycles == TIMEOUT-1` with no match in that cycle.
  - SETTLE → PASS when the settle count reaches `SETTLE_CYCLES` and `gp == 1`.
  - SETTLE → FAIL when the settle count reaches `SETTLE_CYCLES` and `gp != 1`. FAIL latches `fail_test = gp[XLEN-1:1]`.
- PASS, FAIL and TIMEOUT are sticky until reset. Later PC matches and stores are ignored.
- If `SETTLE_CYCLES == 0`, gp is sampled in the match cycle and the block goes RUN → PASS/FAIL directly.
- `cycles` increments in RUN and SETTLE, saturates at all-ones and freezes in the terminal states.
- Timeout is checked only in RUN. SETTLE always completes.
- A match and the timeout condition in the same cycle: the match wins.
- A reset asserted at any point returns the block to RUN with all outputs cleared. There is no idle state: counting starts on the first edge after reset deasserts.

## Timing
- Reset values:
  - state RUN.
  - `done`=0, `pass`=0, `timed_out`=0.
  - `fail_test`=0, `cycles`=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Match sampled at edge k: the gp sample is taken at edge k+SETTLE_CYCLES, and `done` is high from that edge on.
- Timeout: `done` and `timed_out` go high at the edge where `cycles` would become TIMEOUT, so `cycles` reads TIMEOUT-1 afterwards.

## Configuration
- `TEST_MONITOR_TOHOST_EN` defined:
  - Adds the `st_*` ports.
  - In RUN, `st_valid && st_addr == TOHOST_ADDR && st_data[0]` ends the test immediately with no settle delay. `st_data == 1` gives PASS; any other value gives FAIL with `fail_test = st_data[XLEN-1:1]`.
  - A tohost store beats a PC match and a timeout in the same cycle.
- Undefined: the `st_*` ports are absent and only PC-match detection exists.

## Structure
- Package `test_monitor_pkg` holds:
  - the state enum `tm_state_t` (RUN, SETTLE, PASS, FAIL, TIMEOUT);
  - the constants `TM_GP_PASS = 1` and `TM_TOHOST_DONE_BIT = 0`.
- One sub-module, `sat_counter` (parameter `W`; inputs `en` and `clr`; saturating at all-ones). It is used for `cycles` and for the settle count.

## Test plan
- PC reaches 0x44 at cycle 100 with gp=1, SETTLE_CYCLES=2 → `done`=1 and `pass`=1 at cycle 102, `cycles` frozen at 102.
- PC reaches 0x44 with gp=0x0000_000B → FAIL, `fail_test`=5, `pass`=0.
- gp changes from 5 to 1 during SETTLE, one cycle before the sample → PASS (the late write is observed).
- No match, TIMEOUT=50 → `done`=1 and `timed_out`=1 after 50 edges, `cycles`=49. A later match at 0x44 changes nothing.
- With the macro: store of 0x15 to 0x1000 in the same cycle as a PC match → FAIL, `fail_test`=10, no settle delay.
- Reset asserted mid-SETTLE, then released → all outputs 0, counting restarts at 0, and the next match behaves normally.
